// File: rtl/dmem_ctrl_pkg.sv
// Shared types, constants and lane-merge helper for the dmem access sequencer.
package dmem_ctrl_pkg;

  localparam int unsigned MEM_ADDR_W = 32;
  localparam int unsigned MEM_DATA_W = 32;
  localparam logic [3:0]  BE_FULL    = 4'hF;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StWrite,
    StResp
  } state_e;

  typedef struct packed {
    logic                  we;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] wdata;
    logic [3:0]            be;
  } mem_req_t;

  // Byte lane k comes from new_word when be[k] is set, otherwise from old_word.
  function automatic logic [31:0] merge_be(input logic [31:0] old_word,
                                           input logic [31:0] new_word,
                                           input logic [3:0]  be);
    logic [31:0] w;
    w = old_word;
    for (int k = 0; k < 4; k++) begin
      if (be[k]) w[8*k +: 8] = new_word[8*k +: 8];
    end
    return w;
  endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// Request/response ports of the two masters plus the dmem-side strobes.
interface dmem_ctrl_if #(
  parameter int unsigned ADDR_W = 32
);
  logic [1:0]             req_valid_i;
  logic [1:0]             req_ready_o;
  logic [1:0]             req_we_i;
  logic [1:0][ADDR_W-1:0] req_addr_i;
  logic [1:0][31:0]       req_wdata_i;
  logic [1:0][3:0]        req_be_i;
  logic [1:0]             resp_valid_o;
  logic [31:0]            resp_rdata_o;
  logic [ADDR_W-1:0]      mem_addr_o;
  logic [31:0]            mem_wdata_o;
  logic                   mem_read_o;
  logic                   mem_write_o;
  logic [31:0]            mem_rdata_i;

  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_be_i, mem_rdata_i,
    output req_ready_o, resp_valid_o, resp_rdata_o, mem_addr_o, mem_wdata_o,
           mem_read_o, mem_write_o
  );

  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_be_i, mem_rdata_i,
    input  req_ready_o, resp_valid_o, resp_rdata_o, mem_addr_o, mem_wdata_o,
           mem_read_o, mem_write_o
  );
endinterface

// File: rtl/dmem_ctrl_rr_arb2.sv
// Two-way round-robin winner select; the last-grant state lives in the parent.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] gnt,
  output logic       gnt_idx
);
  always_comb begin
    gnt_idx = 1'b0;
    case (valid)
      2'b01:   gnt_idx = 1'b0;
      2'b10:   gnt_idx = 1'b1;
      2'b11:   gnt_idx = ~last_grant;
      default: gnt_idx = 1'b0;
    endcase
    gnt = (valid == 2'b00) ? 2'b00 : (gnt_idx ? 2'b10 : 2'b01);
  end
endmodule

// File: rtl/dmem_ctrl.sv
// Arbitrates two masters onto the word-only dmem, turning partial writes into
// read-modify-write and returning a single-cycle response pulse to the owner.
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input logic        clk,
  input logic        rst,
  dmem_ctrl_if.slave bus
);
  if (DATA_W != 32) begin : g_bad_data_w
    $error("dmem_ctrl: DATA_W must be 32");
  end
  if (ADDR_W < 12 || ADDR_W > MEM_ADDR_W) begin : g_bad_addr_w
    $error("dmem_ctrl: ADDR_W must be in 12..32");
  end

  state_e      state_q, state_d;
  logic        last_grant_q, owner_q;
  mem_req_t    req_q, req_sel;
  logic [31:0] data_q, data_d;
  logic        data_en;
  logic [1:0]  gnt, ready;
  logic        gnt_idx, hs;

  logic        mem_read, mem_write;
  logic [31:0] mem_wdata, resp_rdata;
  logic [1:0]  resp_valid;

  rr_arb2 u_arb (
    .valid      (bus.req_valid_i),
    .last_grant (last_grant_q),
    .gnt        (gnt),
    .gnt_idx    (gnt_idx)
  );

  assign ready = (state_q == StIdle && !rst) ? gnt : 2'b00;
  assign hs    = |(bus.req_valid_i & ready);

  // Low address bits are dropped at capture so the memory only ever sees word addresses.
  always_comb begin
    req_sel.we    = bus.req_we_i[gnt_idx];
    req_sel.addr  = MEM_ADDR_W'({bus.req_addr_i[gnt_idx][ADDR_W-1:2], 2'b00});
    req_sel.wdata = bus.req_wdata_i[gnt_idx];
    req_sel.be    = bus.req_be_i[gnt_idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      req_q        <= '0;
      data_q       <= '0;
    end else begin
      state_q <= state_d;
      if (hs) begin
        last_grant_q <= gnt_idx;
        owner_q      <= gnt_idx;
        req_q        <= req_sel;
      end
      if (data_en) data_q <= data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    data_en    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_wdata  = '0;
    resp_valid = 2'b00;
    resp_rdata = '0;
    unique case (state_q)
      StIdle: begin
        if (hs) state_d = StAccess;
      end
      StAccess: begin
        state_d = StResp;
        if (!req_q.we) begin
          mem_read = 1'b1;
          data_en  = 1'b1;
          data_d   = bus.mem_rdata_i;
        end else if (req_q.be == BE_FULL) begin
          mem_write = 1'b1;
          mem_wdata = req_q.wdata;
        end else if (req_q.be != 4'h0) begin
          mem_read = 1'b1;
          data_en  = 1'b1;
          data_d   = merge_be(bus.mem_rdata_i, req_q.wdata, req_q.be);
          state_d  = StWrite;
        end
      end
      StWrite: begin
        mem_write = 1'b1;
        mem_wdata = data_q;
        state_d   = StResp;
      end
      StResp: begin
        resp_valid[owner_q] = 1'b1;
        resp_rdata          = req_q.we ? '0 : data_q;
        state_d             = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Reset must suppress strobes in the same cycle, so an in-flight RMW never commits.
    if (rst) begin
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_wdata  = '0;
      resp_valid = 2'b00;
      resp_rdata = '0;
    end
  end

  assign bus.req_ready_o  = ready;
  assign bus.resp_valid_o = resp_valid;
  assign bus.resp_rdata_o = resp_rdata;
  assign bus.mem_addr_o   = req_q.addr[ADDR_W-1:0];
  assign bus.mem_wdata_o  = mem_wdata;
  assign bus.mem_read_o   = mem_read;
  assign bus.mem_write_o  = mem_write;

endmodule
